canvas_write_arbiter: RTL and testbench
=======================================

CANVAS_WRITE_ARBITER -- requirements
Module: canvas_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 640, canvas width in pixels.
REQ-002 Parameter HEIGHT, default 480, canvas height in pixels.
REQ-003 Parameter CLEAR_COLOR, default COLOR_NONE, color written by a clear sweep.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 tool_valid  in  1  freehand tool requests one pixel write this cycle.
REQ-007 tool_x / tool_y  in  $clog2(WIDTH) / $clog2(HEIGHT)  tool pixel coordinate.
REQ-008 tool_color  in  COLOR_WIDTH  tool pixel color.
REQ-009 tool_layer  in  3  target layer for tool writes, 1..4; any other value selects no layer.
REQ-010 tool_ready  out  1  combinational; high when a tool request in this cycle is accepted.
REQ-011 clear_req  in  1  single-cycle request to clear the layer on clear_layer.
REQ-012 clear_layer  in  3  layer to clear, 1..4.
REQ-013 wr_en  out  4  one-hot registered write enable; bit n-1 targets canvas n.
REQ-014 wr_x / wr_y / wr_color  out  coordinate / COLOR_WIDTH  registered write address and data.
REQ-015 busy  out  1  high while a clear sweep is in progress.
REQ-016 clear_done  out  1  single-cycle pulse after the last clear write.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR and DONE.
REQ-018 IDLE -> CLEAR SHALL occur when clear_req=1 and clear_layer is 1..4; the target layer is latched and the sweep counters are set to (0,0).
REQ-019 clear_req SHALL be ignored in CLEAR or DONE, or when clear_layer is outside 1..4.
REQ-020 In CLEAR, each granted sweep cycle SHALL write CLEAR_COLOR at (cx,cy), then advance cx; at cx=WIDTH-1, cx wraps to 0 and cy increments.
REQ-021 CLEAR -> DONE SHALL occur on the cycle the write to (WIDTH-1,HEIGHT-1) is issued; DONE -> IDLE after one cycle, with clear_done=1 during DONE only.
REQ-022 busy SHALL be 1 exactly in CLEAR.
REQ-023 In IDLE or DONE, tool_ready SHALL equal 1; an accepted tool_valid with tool_layer in 1..4 SHALL drive wr_en one-hot for that layer next cycle, with wr_x/wr_y/wr_color copied from the tool.
REQ-024 An accepted tool request with tool_layer outside 1..4 SHALL produce wr_en=0.
REQ-025 Write latency SHALL be exactly one cycle from request or sweep step to wr_* outputs; at most one wr_en bit is high per cycle.
REQ-026 With no accepted write in a cycle, wr_en SHALL be 0 next cycle; wr_x/wr_y/wr_color hold their previous values.
REQ-027 Simultaneous clear_req and tool_valid in IDLE: the tool write SHALL issue that cycle, and the sweep SHALL start next cycle.

Reset
REQ-028 While reset=0: state=IDLE; wr_en=0; wr_x=0; wr_y=0; wr_color=0; busy=0; clear_done=0; sweep counters=0.
REQ-029 Asserting reset mid-sweep SHALL abort the sweep immediately without any clear_done pulse; the partially cleared canvas is left as is.

Configuration
REQ-030 Macro CANVAS_CLEAR_YIELD_EN defined: in CLEAR, tool_ready=1; a tool request preempts the sweep, issuing the tool write that cycle while the sweep counter stalls; the sweep resumes at the same pixel.
REQ-031 CANVAS_CLEAR_YIELD_EN undefined: in CLEAR, tool_ready=0; tool requests are dropped and the sweep never stalls.

Verification (WIDTH=8, HEIGHT=8)
REQ-032 Reset mid-operation: release reset, tool_valid=1, tool_layer=2, (3,5), color 5 -> next cycle wr_en=4'b0010, wr_x=3, wr_y=5, wr_color=5.
REQ-033 Clear: clear_req=1, clear_layer=1, no tool traffic -> busy for 64 cycles; wr_en=4'b0001 each cycle for (0,0)..(7,7) in raster order; wr_color=CLEAR_COLOR; clear_done pulses once; then IDLE.
REQ-034 clear_req with clear_layer=0 or 5, and a second clear_req during CLEAR -> no state change and no extra sweep.
REQ-035 Tool write during CLEAR with the macro defined: tool request at sweep pixel (2,1) -> tool write issued, sweep resumes at (2,1), total sweep 65 cycles. With the macro undefined: tool_ready=0, write dropped, sweep 64 cycles.
REQ-036 reset=0 at sweep pixel (4,3) -> outputs take reset values immediately; after release, state=IDLE and clear_done never pulses.

Source files
------------

// File: rtl/canvas_write_arbiter.sv
// Arbitrates freehand-tool pixel writes against a full-layer clear sweep onto four canvas layers.
// Optional CANVAS_CLEAR_YIELD_EN lets tool writes preempt an in-progress sweep.
module canvas_write_arbiter #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COLOR_WIDTH = 8,
    // Default corresponds to COLOR_NONE (all zeros).
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tool_valid,
    input  logic [$clog2(WIDTH)-1:0]   tool_x,
    input  logic [$clog2(HEIGHT)-1:0]  tool_y,
    input  logic [COLOR_WIDTH-1:0]     tool_color,
    input  logic [2:0]                 tool_layer,
    output logic                       tool_ready,
    input  logic                       clear_req,
    input  logic [2:0]                 clear_layer,
    output logic [3:0]                 wr_en,
    output logic [$clog2(WIDTH)-1:0]   wr_x,
    output logic [$clog2(HEIGHT)-1:0]  wr_y,
    output logic [COLOR_WIDTH-1:0]     wr_color,
    output logic                       busy,
    output logic                       clear_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             layer_q, layer_d;
    logic [XW-1:0]          cx_q, cx_d;
    logic [YW-1:0]          cy_q, cy_d;
    logic [3:0]             wr_en_q, wr_en_d;
    logic [XW-1:0]          wr_x_q, wr_x_d;
    logic [YW-1:0]          wr_y_q, wr_y_d;
    logic [COLOR_WIDTH-1:0] wr_color_q, wr_color_d;

    logic       take_sweep;
    logic       take_tool;
    logic [3:0] tool_onehot;
    logic [3:0] clear_onehot;

    // Layers are numbered 1..4; anything else maps to no write enable.
    function automatic logic [3:0] layer_onehot(input logic [2:0] layer);
        logic [3:0] oh;
        oh = 4'b0000;
        case (layer)
            3'd1:    oh = 4'b0001;
            3'd2:    oh = 4'b0010;
            3'd3:    oh = 4'b0100;
            3'd4:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    assign tool_onehot  = layer_onehot(tool_layer);
    assign clear_onehot = layer_onehot(clear_layer);

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        tool_ready = 1'b0;
        take_sweep = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tool_ready = 1'b1;
                if (clear_req && (clear_onehot != 4'b0000)) begin
                    state_d = ST_CLEAR;
                    layer_d = clear_layer;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            ST_CLEAR: begin
`ifdef CANVAS_CLEAR_YIELD_EN
                tool_ready = 1'b1;
                take_sweep = ~tool_valid;
`else
                tool_ready = 1'b0;
                take_sweep = 1'b1;
`endif
            end
            ST_DONE: begin
                tool_ready = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Raster advance; the final pixel write moves the FSM to DONE.
        if (take_sweep) begin
            if (cx_q == X_LAST) begin
                cx_d = '0;
                if (cy_q == Y_LAST) begin
                    cy_d    = '0;
                    state_d = ST_DONE;
                end else begin
                    cy_d = cy_q + YW'(1);
                end
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end
    end

    assign take_tool = tool_valid & tool_ready;

    // Address/data only move when a write is actually issued.
    always_comb begin
        wr_en_d    = 4'b0000;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        if (take_tool) begin
            if (tool_onehot != 4'b0000) begin
                wr_en_d    = tool_onehot;
                wr_x_d     = tool_x;
                wr_y_d     = tool_y;
                wr_color_d = tool_color;
            end
        end else if (take_sweep) begin
            wr_en_d    = layer_onehot(layer_q);
            wr_x_d     = cx_q;
            wr_y_d     = cy_q;
            wr_color_d = CLEAR_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            layer_q    <= 3'd0;
            cx_q       <= '0;
            cy_q       <= '0;
            wr_en_q    <= 4'b0000;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_color_q <= '0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_color   = wr_color_q;
    assign busy       = (state_q == ST_CLEAR);
    assign clear_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Randomized and directed bench for canvas_write_arbiter on an 8x8 canvas,
// checked cycle by cycle against a pixel-index model of the arbiter.
module tb_canvas_write_arbiter;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 8;
    localparam logic [CW-1:0] CLR = 8'hA5;
`ifdef CANVAS_CLEAR_YIELD_EN
    localparam bit YIELD = 1'b1;
`else
    localparam bit YIELD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tool_valid;
    logic [2:0]    tool_x;
    logic [2:0]    tool_y;
    logic [CW-1:0] tool_color;
    logic [2:0]    tool_layer;
    logic          tool_ready;
    logic          clear_req;
    logic [2:0]    clear_layer;
    logic [3:0]    wr_en;
    logic [2:0]    wr_x;
    logic [2:0]    wr_y;
    logic [CW-1:0] wr_color;
    logic          busy;
    logic          clear_done;

    canvas_write_arbiter #(
        .WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW), .CLEAR_COLOR(CLR)
    ) dut (
        .clk(clk), .reset(reset),
        .tool_valid(tool_valid), .tool_x(tool_x), .tool_y(tool_y),
        .tool_color(tool_color), .tool_layer(tool_layer), .tool_ready(tool_ready),
        .clear_req(clear_req), .clear_layer(clear_layer),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .busy(busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    logic [19:0] act_vec;
    assign act_vec = {wr_en, wr_x, wr_y, wr_color, busy, clear_done};

    int n_checks = 0;
    int n_errors = 0;

    // Model: a sweep is just a pixel index 0..W*H-1 walked in raster order.
    bit            m_busy, m_done;
    int            m_idx, m_layer;
    logic [3:0]    e_en;
    logic [2:0]    e_x, e_y;
    logic [CW-1:0] e_c;

    function automatic bit m_ready();
        return !m_busy || YIELD;
    endfunction

    function automatic logic [19:0] exp_vec();
        return {e_en, e_x, e_y, e_c, m_busy, m_done};
    endfunction

    function automatic bit layer_ok(input int l);
        return (l >= 1) && (l <= 4);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_idx = 0; m_layer = 0;
        e_en = '0; e_x = '0; e_y = '0; e_c = '0;
    endtask

    task automatic model_step();
        bit n_busy;
        bit n_done;
        bit was_idle;
        n_busy   = m_busy;
        n_done   = 0;
        was_idle = !m_busy && !m_done;
        e_en     = 4'b0000;
        if (tool_valid && m_ready()) begin
            if (layer_ok(int'(tool_layer))) begin
                e_en = 4'(1 << (int'(tool_layer) - 1));
                e_x = tool_x; e_y = tool_y; e_c = tool_color;
            end
        end else if (m_busy) begin
            e_en = 4'(1 << (m_layer - 1));
            e_x  = 3'(m_idx % W);
            e_y  = 3'(m_idx / W);
            e_c  = CLR;
            m_idx++;
            if (m_idx == W * H) begin
                n_busy = 0;
                n_done = 1;
            end
        end
        if (was_idle && clear_req && layer_ok(int'(clear_layer))) begin
            n_busy  = 1;
            m_idx   = 0;
            m_layer = int'(clear_layer);
        end
        m_busy = n_busy;
        m_done = n_done;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        tool_valid = 0; clear_req = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; quiet();
        tool_x = '0; tool_y = '0; tool_color = '0; tool_layer = '0; clear_layer = '0;
        model_reset();
        #2 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (act_vec !== 20'h0) begin
            n_errors++; $display("FAIL reset_outputs got=%h exp=%h", act_vec, 20'h0);
        end
        n_checks++;
        if (tool_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_tool_ready got=%b exp=1", tool_ready);
        end
        reset = 1'b1;
        $display("reset: outputs=%h", act_vec);
    endtask

    task automatic test_tool_write();
        tool_valid = 1; tool_layer = 3'd2; tool_x = 3'd3; tool_y = 3'd5; tool_color = 8'd5;
        tick();
        quiet();
        n_checks++;
        if (wr_en !== 4'b0010 || wr_x !== 3'd3 || wr_y !== 3'd5 || wr_color !== 8'd5) begin
            n_errors++;
            $display("FAIL tool_write got en=%b x=%0d y=%0d c=%0d exp en=0010 x=3 y=5 c=5",
                     wr_en, wr_x, wr_y, wr_color);
        end
        tick();
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_errors++; $display("FAIL tool_write_idle got=%h exp=%h", act_vec, exp_vec());
        end
        $display("tool write: en=%b (%0d,%0d) color=%0d", 4'b0010, 3, 5, 5);
    endtask

    task automatic test_random_tool();
        for (int i = 0; i < 40; i++) begin
            tool_valid = 1'($urandom % 2); tool_layer = 3'($urandom % 8);
            tool_x = 3'($urandom); tool_y = 3'($urandom); tool_color = 8'($urandom);
            n_checks++;
            if (tool_ready !== m_ready()) begin
                n_errors++; $display("FAIL rand_tool_ready i=%0d got=%b exp=%b", i, tool_ready, m_ready());
            end
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL rand_tool i=%0d got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
        quiet();
        tick();
        $display("random tool writes: 40 cycles");
    endtask

    task automatic test_clear();
        int busy_n = 0, done_n = 0, wr_n = 0, guard = 0;
        clear_req = 1; clear_layer = 3'd1;
        do begin
            tick();
            clear_req = 0;
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL clear_cycle g=%0d got=%h exp=%h", guard, act_vec, exp_vec());
            end
            busy_n += int'(busy); done_n += int'(clear_done); wr_n += int'(wr_en == 4'b0001);
            guard++;
        end while ((m_busy || m_done || busy || clear_done) && guard < 200);
        n_checks++;
        if (busy_n != 64 || done_n != 1 || wr_n != 64 || guard >= 200) begin
            n_errors++;
            $display("FAIL clear_counts got busy=%0d done=%0d writes=%0d exp busy=64 done=1 writes=64",
                     busy_n, done_n, wr_n);
        end
        $display("clear layer 1: busy=%0d writes=%0d done=%0d", busy_n, wr_n, done_n);
    endtask

    task automatic test_ignored_clear();
        int busy_n = 0, done_n = 0, guard = 0;
        clear_req = 1; clear_layer = 3'd0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL clear_layer0 busy got=%b exp=0", busy); end
        clear_layer = 3'd5;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL clear_layer5 busy got=%b exp=0", busy); end
        clear_layer = 3'd3;
        do begin
            tick();
            clear_req   = (guard == 10);
            clear_layer = (guard == 10) ? 3'd2 : 3'd3;
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL ignored_clear g=%0d got=%h exp=%h", guard, act_vec, exp_vec());
            end
            busy_n += int'(busy); done_n += int'(clear_done);
            guard++;
        end while ((m_busy || m_done || busy || clear_done) && guard < 200);
        quiet();
        n_checks++;
        if (busy_n != 64 || done_n != 1) begin
            n_errors++; $display("FAIL ignored_clear_counts got busy=%0d done=%0d exp busy=64 done=1", busy_n, done_n);
        end
        $display("clear layer 3 with stray requests: busy=%0d done=%0d", busy_n, done_n);
    endtask

    task automatic test_tool_during_clear();
        int busy_n = 0, guard = 0;
        bit injected = 0, check_next = 0;
        clear_req = 1; clear_layer = 3'd4;
        do begin
            if (m_busy && m_idx == 10 && !injected) begin
                tool_valid = 1; tool_layer = 3'd2; tool_x = 3'd7; tool_y = 3'd7; tool_color = 8'd9;
                injected = 1; check_next = 1;
                n_checks++;
                if (tool_ready !== YIELD) begin
                    n_errors++; $display("FAIL yield_ready got=%b exp=%b", tool_ready, YIELD);
                end
            end
            tick();
            clear_req = 0; tool_valid = 0;
            if (check_next) begin
                check_next = 0;
                n_checks++;
                if (wr_en !== (YIELD ? 4'b0010 : 4'b1000)) begin
                    n_errors++; $display("FAIL yield_write got en=%b exp=%b", wr_en, YIELD ? 4'b0010 : 4'b1000);
                end
            end
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL tool_in_clear g=%0d got=%h exp=%h", guard, act_vec, exp_vec());
            end
            busy_n += int'(busy);
            guard++;
        end while ((m_busy || m_done || busy || clear_done) && guard < 200);
        n_checks++;
        if (busy_n != 64 + int'(YIELD)) begin
            n_errors++; $display("FAIL yield_sweep_len got=%0d exp=%0d", busy_n, 64 + int'(YIELD));
        end
        $display("clear layer 4 with tool at (2,1): busy=%0d", busy_n);
    endtask

    task automatic test_simultaneous();
        int guard = 0;
        tool_valid = 1; tool_layer = 3'd3; tool_x = 3'd6; tool_y = 3'd1; tool_color = 8'd77;
        clear_req = 1; clear_layer = 3'd1;
        tick();
        quiet();
        n_checks++;
        if (wr_en !== 4'b0100 || wr_x !== 3'd6 || wr_color !== 8'd77 || busy !== 1'b1) begin
            n_errors++; $display("FAIL simul_first got en=%b x=%0d c=%0d busy=%b exp en=0100 x=6 c=77 busy=1",
                                 wr_en, wr_x, wr_color, busy);
        end
        tick();
        n_checks++;
        if (wr_en !== 4'b0001 || wr_x !== 3'd0 || wr_y !== 3'd0 || wr_color !== CLR) begin
            n_errors++; $display("FAIL simul_sweep0 got en=%b x=%0d y=%0d c=%h exp en=0001 x=0 y=0 c=%h",
                                 wr_en, wr_x, wr_y, wr_color, CLR);
        end
        do begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL simul_drain g=%0d got=%h exp=%h", guard, act_vec, exp_vec());
            end
            guard++;
        end while ((m_busy || m_done || busy || clear_done) && guard < 200);
        $display("simultaneous tool+clear: drained in %0d cycles", guard);
    endtask

    task automatic test_reset_mid_sweep();
        int guard = 0, done_n = 0;
        clear_req = 1; clear_layer = 3'd2;
        do begin
            tick();
            clear_req = 0;
            guard++;
        end while (!(m_busy && m_idx == 28) && guard < 200);
        n_checks++;
        if (busy !== 1'b1 || guard >= 200) begin
            n_errors++; $display("FAIL midsweep_reach got busy=%b g=%0d exp busy=1", busy, guard);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (act_vec !== 20'h0) begin
            n_errors++; $display("FAIL midsweep_async got=%h exp=%h", act_vec, 20'h0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL after_reset i=%0d got=%h exp=%h", i, act_vec, exp_vec());
            end
            done_n += int'(clear_done);
        end
        n_checks++;
        if (done_n != 0) begin
            n_errors++; $display("FAIL midsweep_done_pulses got=%0d exp=0", done_n);
        end
        $display("reset at sweep pixel (4,3): done pulses=%0d", done_n);
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        for (int i = 0; i < 400; i++) begin
            tool_valid = 1'($urandom % 2); tool_layer = 3'($urandom % 8);
            tool_x = 3'($urandom); tool_y = 3'($urandom); tool_color = 8'($urandom);
            clear_req = ($urandom % 30) == 0; clear_layer = 3'($urandom % 8);
            n_checks++;
            if (tool_ready !== m_ready()) begin
                n_errors++; $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, tool_ready, m_ready());
            end
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL b2b i=%0d got=%h exp=%h", i, act_vec, exp_vec());
            end
        end
        quiet();
        do begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL b2b_drain g=%0d got=%h exp=%h", guard, act_vec, exp_vec());
            end
            guard++;
        end while ((m_busy || m_done || busy || clear_done) && guard < 200);
        $display("back-to-back random: 400 cycles, drain %0d", guard);
    endtask

    initial begin
        test_reset();
        test_tool_write();
        test_random_tool();
        test_clear();
        test_ignored_clear();
        test_tool_during_clear();
        test_simultaneous();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
